// File: rtl/tim_apb_requester.sv
// tim_apb_requester: turns single valid/ready commands into APB transfers and
// returns one response per command. At most one transfer is in flight.
// Optional build macro APB_TIMEOUT_EN: aborts an ACCESS phase that has seen no
// pready for TIMEOUT_CYCLES cycles and returns an error response.
module tim_apb_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    // command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [11:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_strb,
    // response side
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    // APB requester
    output logic        tim_psel,
    output logic        tim_penable,
    output logic        tim_pwrite,
    output logic [11:0] tim_paddr,
    output logic [31:0] tim_pwdata,
    output logic [3:0]  tim_pstrb,
    input  logic        tim_pready,
    input  logic        tim_pslverr,
    input  logic [31:0] tim_prdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t state;
    logic   wr_q;       // direction of the transfer in flight, survives APB clear

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tout_cnt;
`endif

    // Transfer sequencer; every output is a flop loaded on state transitions
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            tim_psel    <= 1'b0;
            tim_penable <= 1'b0;
            tim_pwrite  <= 1'b0;
            tim_paddr   <= '0;
            tim_pwdata  <= '0;
            tim_pstrb   <= '0;
`ifdef APB_TIMEOUT_EN
            tout_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready  <= 1'b0;
                        wr_q       <= cmd_write;
                        tim_psel   <= 1'b1;
                        tim_pwrite <= cmd_write;
                        tim_paddr  <= cmd_addr;
                        // reads carry no data and no strobes on the bus
                        tim_pwdata <= cmd_write ? cmd_wdata : 32'd0;
                        tim_pstrb  <= cmd_write ? cmd_strb : 4'd0;
                        state      <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    tim_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    tout_cnt    <= '0;
`endif
                    state       <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (tim_pready) begin
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= wr_q ? 32'd0 : tim_prdata;
                        rsp_err     <= tim_pslverr;
                        tim_psel    <= 1'b0;
                        tim_penable <= 1'b0;
                        tim_pwrite  <= 1'b0;
                        tim_paddr   <= '0;
                        tim_pwdata  <= '0;
                        tim_pstrb   <= '0;
                        state       <= ST_RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (tout_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // this stalled cycle brings the count to the limit
                        tout_cnt    <= tout_cnt + CNT_W'(1);
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        tim_psel    <= 1'b0;
                        tim_penable <= 1'b0;
                        tim_pwrite  <= 1'b0;
                        tim_paddr   <= '0;
                        tim_pwdata  <= '0;
                        tim_pstrb   <= '0;
                        state       <= ST_RESP;
                    end else begin
                        tout_cnt <= tout_cnt + CNT_W'(1);
                    end
`endif
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tim_apb_requester.sv
// Directed bench for tim_apb_requester: vector table plus backpressure,
// stall/timeout and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_tim_apb_requester;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [11:0] cmd_addr  = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb  = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        tim_psel, tim_penable, tim_pwrite;
    logic [11:0] tim_paddr;
    logic [31:0] tim_pwdata;
    logic [3:0]  tim_pstrb;
    logic        tim_pready  = 1'b0;
    logic        tim_pslverr = 1'b0;
    logic [31:0] tim_prdata  = '0;

    tim_apb_requester #(.TIMEOUT_CYCLES(16)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .tim_psel    (tim_psel),
        .tim_penable (tim_penable),
        .tim_pwrite  (tim_pwrite),
        .tim_paddr   (tim_paddr),
        .tim_pwdata  (tim_pwdata),
        .tim_pstrb   (tim_pstrb),
        .tim_pready  (tim_pready),
        .tim_pslverr (tim_pslverr),
        .tim_prdata  (tim_prdata)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;      // ACCESS cycles with pready low before completion
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Waits (bounded) for cmd_ready while cmd_valid is already driven; returns at the negedge after accept
    task automatic accept_cmd(input string tag);
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge sys_clk);
            guard++;
        end
        chk({tag, " accept"}, 32'(cmd_ready), 32'd1);
        @(negedge sys_clk);
        // scramble command inputs: the DUT must have captured them
        cmd_valid = 1'b0;
        cmd_addr  = 12'hABC;
        cmd_wdata = 32'hFFFF_FFFF;
        cmd_strb  = 4'hF;
    endtask

    // One full transfer; hold>0 stalls the response for that many cycles while a new command waits
    task automatic run_xfer(input vec_t v, input int hold);
        int lat = 1, ps = 0, pe = 0, unstable = 0;
        bit got = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        accept_cmd(v.name);
        chk({v.name, " setup psel"}, 32'({tim_psel, tim_penable}), 32'b10);
        while (!got && lat < 60) begin
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                if (tim_psel === 1'b1) begin
                    ps++;
                    if (tim_paddr !== v.addr || tim_pwdata !== v.exp_pwdata ||
                        tim_pstrb !== v.exp_pstrb || tim_pwrite !== v.wr)
                        unstable++;
                end
                if (tim_penable === 1'b1) begin
                    pe++;
                    if (pe > v.waits) begin
                        tim_pready = 1'b1; tim_prdata = v.prdata; tim_pslverr = v.slverr;
                    end else begin
                        tim_pready = 1'b0; tim_prdata = 32'hDEAD_BEEF; tim_pslverr = 1'b1;
                    end
                end else begin
                    // junk outside ACCESS must be ignored
                    tim_pready = 1'b1; tim_prdata = 32'h5A5A_5A5A; tim_pslverr = 1'b1;
                end
                @(negedge sys_clk);
                lat++;
            end
        end
        tim_pready = 1'b0; tim_prdata = 32'h5A5A_5A5A; tim_pslverr = 1'b1;
        chk({v.name, " latency"}, 32'(lat), 32'(3 + v.waits));
        chk({v.name, " psel cycles"}, 32'(ps), 32'(2 + v.waits));
        chk({v.name, " penable cycles"}, 32'(pe), 32'(1 + v.waits));
        chk({v.name, " bus unstable"}, 32'(unstable), 32'd0);
        chk({v.name, " rdata"}, rsp_rdata, v.exp_rdata);
        chk({v.name, " err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({v.name, " bus idle in resp"},
            32'({tim_psel, tim_penable, tim_pwrite}) | 32'(tim_paddr) | tim_pwdata | 32'(tim_pstrb), 32'd0);
        if (hold > 0) begin
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020;
            for (int i = 0; i < hold; i++) begin
                @(negedge sys_clk);
                chk({v.name, " hold cmd_ready"}, 32'(cmd_ready), 32'd0);
                chk({v.name, " hold psel"}, 32'(tim_psel), 32'd0);
                chk({v.name, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
                chk({v.name, " hold rdata"}, rsp_rdata, v.exp_rdata);
            end
        end
        rsp_ready = 1'b1;
        @(negedge sys_clk);
        rsp_ready = 1'b0;
        chk({v.name, " rsp consumed"}, 32'(rsp_valid), 32'd0);
        chk({v.name, " ready again"}, 32'(cmd_ready), 32'd1);
        chk({v.name, " no psel in idle"}, 32'(tim_psel), 32'd0);
    endtask

    // Keeps pready low for a long stretch: aborts with the timeout build, waits otherwise
    task automatic stall_seq();
        int ps = 0, pe = 0, n = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040;
        cmd_wdata = '0; cmd_strb = '0;
        accept_cmd("stall");
        tim_pready = 1'b0; tim_prdata = 32'hBAD0_BAD0; tim_pslverr = 1'b0;
`ifdef APB_TIMEOUT_EN
        while (rsp_valid !== 1'b1 && n < 60) begin
            if (tim_psel === 1'b1) ps++;
            if (tim_penable === 1'b1) pe++;
            @(negedge sys_clk);
            n++;
        end
        chk("timeout psel cycles", 32'(ps), 32'd17);
        chk("timeout penable cycles", 32'(pe), 32'd16);
        chk("timeout rsp_valid", 32'(rsp_valid), 32'd1);
        chk("timeout err", 32'(rsp_err), 32'd1);
        chk("timeout rdata", rsp_rdata, 32'd0);
        chk("timeout psel dropped", 32'(tim_psel), 32'd0);
`else
        while (n < 40) begin
            if (tim_psel === 1'b1) ps++;
            if (tim_penable === 1'b1) pe++;
            @(negedge sys_clk);
            n++;
        end
        chk("stall psel cycles", 32'(ps), 32'd40);
        chk("stall penable cycles", 32'(pe), 32'd39);
        chk("stall no rsp", 32'(rsp_valid), 32'd0);
        tim_pready = 1'b1; tim_prdata = 32'h0000_600D;
        @(negedge sys_clk);
        tim_pready = 1'b0;
        chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall rdata", rsp_rdata, 32'h0000_600D);
        chk("stall err", 32'(rsp_err), 32'd0);
`endif
        rsp_ready = 1'b1;
        @(negedge sys_clk);
        rsp_ready = 1'b0;
        chk("stall ready again", 32'(cmd_ready), 32'd1);
    endtask

    // Asynchronous reset in the middle of ACCESS: outputs clear at once, no response follows
    task automatic reset_seq();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h030;
        cmd_wdata = 32'h1111_2222; cmd_strb = 4'hF;
        accept_cmd("rst");
        tim_pready = 1'b0;
        @(negedge sys_clk);
        chk("rst in access", 32'({tim_psel, tim_penable}), 32'b11);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst async psel/penable", 32'({tim_psel, tim_penable}), 32'd0);
        chk("rst async rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst async cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst async bus", 32'(tim_paddr) | tim_pwdata | 32'(tim_pstrb), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tim_pready = 1'b1;
        @(negedge sys_clk);
        chk("rst release cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            chk("rst no response", 32'({rsp_valid, tim_psel}), 32'd0);
        end
        tim_pready = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        vec_t vb;
        vecs[0] = '{"wr014", 1'b1, 12'h014, 32'h0000_0001, 4'b1111, 2, 32'hCCCC_CCCC, 1'b0,
                    32'h0000_0001, 4'b1111, 32'h0, 1'b0};
        vecs[1] = '{"rd004", 1'b0, 12'h004, 32'h7777_7777, 4'b1111, 0, 32'h1234_5678, 1'b0,
                    32'h0, 4'b0000, 32'h1234_5678, 1'b0};
        vecs[2] = '{"wr018err", 1'b1, 12'h018, 32'h0000_AA55, 4'b0101, 1, 32'hCAFE_F00D, 1'b1,
                    32'h0000_AA55, 4'b0101, 32'h0, 1'b1};
        vecs[3] = '{"rd018", 1'b0, 12'h018, 32'h0, 4'b0000, 3, 32'h0BAD_F00D, 1'b0,
                    32'h0, 4'b0000, 32'h0BAD_F00D, 1'b0};
        vecs[4] = '{"rd003err", 1'b0, 12'h003, 32'h0, 4'b1010, 0, 32'hFFFF_FFFF, 1'b1,
                    32'h0, 4'b0000, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{"wrFFF", 1'b1, 12'hFFF, 32'h8000_0000, 4'b1000, 5, 32'h1, 1'b0,
                    32'h8000_0000, 4'b1000, 32'h0, 1'b0};
        vb      = '{"rdhold", 1'b0, 12'h00C, 32'h0, 4'b0000, 0, 32'h00C0_FFEE, 1'b0,
                    32'h0, 4'b0000, 32'h00C0_FFEE, 1'b0};

        #1 sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset outputs", 32'({rsp_valid, rsp_err, tim_psel, tim_penable, tim_pwrite}), 32'd0);
        chk("reset rdata", rsp_rdata, 32'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("post-reset cmd_ready", 32'(cmd_ready), 32'd1);

        foreach (vecs[i]) run_xfer(vecs[i], 0);

        // response held off for 5 cycles with a command pending, then released
        run_xfer(vb, 5);
        run_xfer(vecs[1], 0);

        stall_seq();
        reset_seq();
        run_xfer(vecs[3], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tim_apb_requester.md
TIM_APB_REQUESTER -- requirements
Module: tim_apb_requester

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of ACCESS cycles allowed before abort (used only with APB_TIMEOUT_EN).
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 sys_clk  in  1  clock; all state changes on the rising edge.
REQ-004 sys_rst_n  in  1  asynchronous active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 cmd_write  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  12  register byte address.
REQ-009 cmd_wdata  in  32  write data.
REQ-010 cmd_strb  in  4  write byte strobes.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-013 rsp_rdata  out  32  read data (0 for writes).
REQ-014 rsp_err  out  1  slave error or timeout.
REQ-015 tim_psel, tim_penable, tim_pwrite  out  1 each  APB control.
REQ-016 tim_paddr  out  12; tim_pwdata  out  32; tim_pstrb  out  4  APB address, write data and strobes.
REQ-017 tim_pready, tim_pslverr  in  1 each; tim_prdata  in  32  APB completion inputs.

Function
REQ-018 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
REQ-019 cmd_ready SHALL be 1 only in IDLE; there is no combinational path from cmd_valid to cmd_ready.
REQ-020 An accepted command SHALL register addr/wdata/strb/write and move to SETUP on the next edge.
REQ-021 SETUP, exactly one cycle: psel=1, penable=0, address/control/data stable.
REQ-022 ACCESS: psel=1, penable=1, all APB outputs held unchanged until a cycle with tim_pready=1.
REQ-023 On the pready edge, SHALL capture tim_prdata (reads only, else 0) and tim_pslverr, drop psel/penable, and enter RESP.
REQ-024 Minimum latency: command accept to rsp_valid is 3 cycles with zero wait states.
REQ-025 RESP: rsp_valid=1 with rdata/err held stable until rsp_ready=1, then return to IDLE on that edge.
REQ-026 Back-to-back commands: no new APB transfer starts before the previous response is consumed; at most one transfer is outstanding.
REQ-027 For reads, tim_pstrb SHALL be 4'b0000 and tim_pwdata 0.
REQ-028 Outside SETUP/ACCESS, all APB outputs SHALL be 0.
REQ-029 tim_pslverr and tim_prdata SHALL be ignored in any cycle without psel && penable && pready.
REQ-030 tim_paddr SHALL be driven unmodified, with no alignment masking.

Reset
REQ-031 Asserting sys_rst_n=0 SHALL immediately force IDLE and clear the captured command, the timeout counter and all outputs to 0, except cmd_ready, which becomes 1 on the first edge after deassertion.
REQ-032 Reset during SETUP/ACCESS SHALL abort the transfer with no response generated.

Configuration
REQ-033 Macro APB_TIMEOUT_EN defined: a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0. When it reaches TIMEOUT_CYCLES, the block SHALL drop psel/penable, enter RESP with rsp_err=1 and rsp_rdata=0. pready on the same cycle as the limit wins, giving a normal completion.
REQ-034 Macro APB_TIMEOUT_EN undefined: there is no counter and ACCESS waits indefinitely.

Verification
REQ-035 Write addr 0x014, data 0x00000001, strb 4'b1111, pready low 2 ACCESS cycles then high -> psel high 4 cycles, penable high 3 cycles, pwdata stable throughout, rsp_err=0, rsp_rdata=0.
REQ-036 Read addr 0x004, pready=1 immediately, prdata=0x12345678 -> pstrb=0000, rsp_valid 3 cycles after accept, rsp_rdata=0x12345678, rsp_err=0.
REQ-037 Write addr 0x018 with pslverr=1 on the completion cycle -> rsp_err=1; a following read of 0x018 with pslverr=0 -> rsp_err=0.
REQ-038 Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> cmd_ready stays 0, no psel, rsp_rdata unchanged; release -> the next transfer starts 1 cycle later.
REQ-039 With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held 0 -> psel drops after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0.
REQ-040 Assert sys_rst_n=0 mid-ACCESS -> psel/penable/rsp_valid are 0 without waiting for a clock edge, and cmd_ready=1 after release.
